// File: rtl/data_mem_responder.sv
// Word-organised data RAM with a fixed wait-state count and a 4-phase
// req/ready handshake, serving the MEM stage of the multi-cycle CPU.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic        DataMemRW,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_rw;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] mem [DEPTH];

  logic        cur_rw;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        access;
  logic        addr_ok;
  logic [AW-1:0] idx;

  // Select request fields: live inputs when accepting in IDLE (zero-wait
  // case), latched copies otherwise; flag the edge that enters RESP.
  always_comb begin
    cur_rw    = lat_rw;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == S_IDLE) begin
      cur_rw    = DataMemRW;
      cur_addr  = addr;
      cur_wdata = wdata;
    end
    access  = RST && (((state == S_IDLE) && req && ZERO_WAIT) ||
                      ((state == S_WAIT) && (cnt == 4'd1)));
    addr_ok = (cur_addr[1:0] == 2'b00) && (cur_addr[31:2] < DEPTH_W);
    idx     = cur_addr[AW+1:2];
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (access && addr_ok && cur_rw) begin
      mem[idx] <= cur_wdata;
    end
  end

  // Handshake FSM with registered outputs; RESP-entry actions are shared
  // between the zero-wait IDLE path and the WAIT expiry path via 'access'.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_rw    <= DataMemRW;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            busy      <= 1'b1;
            if (ZERO_WAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (!req) begin
            state <= S_IDLE;
            ready <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (access) begin
        ready <= 1'b1;
        err   <= !addr_ok;
        if (addr_ok && !cur_rw) begin
          rdata <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with zero wait states, sharing a clock.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        rst2, req2, rw2, rdy2, err2, busy2;
  logic [31:0] addr2, wd2, rd2;
  logic        rst0, req0, rw0, rdy0, err0, busy0;
  logic [31:0] addr0, wd0, rd0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut2 (
    .CLK(CLK), .RST(rst2), .req(req2), .DataMemRW(rw2), .addr(addr2),
    .wdata(wd2), .rdata(rd2), .ready(rdy2), .err(err2), .busy(busy2)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RST(rst0), .req(req0), .DataMemRW(rw0), .addr(addr0),
    .wdata(wd0), .rdata(rd0), .ready(rdy0), .err(err0), .busy(busy0)
  );

  // Complete handshake on instance 'inst' (0 or 2); lat counts edges from
  // the accepting edge (1) to the edge raising ready, -1 if it never rises.
  task automatic access(input int inst, input logic rw, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic e,
                        output logic [31:0] rd, output logic rdy_after,
                        output logic busy_after);
    @(negedge CLK);
    if (inst == 0) begin req0 = 1'b1; rw0 = rw; addr0 = a; wd0 = d; end
    else begin req2 = 1'b1; rw2 = rw; addr2 = a; wd2 = d; end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if ((inst == 0) ? rdy0 : rdy2) begin lat = i; break; end
    end
    e  = (inst == 0) ? err0 : err2;
    rd = (inst == 0) ? rd0 : rd2;
    @(negedge CLK);
    if (inst == 0) req0 = 1'b0; else req2 = 1'b0;
    @(posedge CLK); #1;
    rdy_after  = (inst == 0) ? rdy0 : rdy2;
    busy_after = (inst == 0) ? busy0 : busy2;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 00000000", rd2); end
    checks++; if ({rdy2, err2, busy2} !== 3'b000) begin errors++; $display("FAIL reset_flags2 got %b exp 000", {rdy2, err2, busy2}); end
    checks++; if ({rdy0, err0, busy0, rd0} !== 35'h0) begin errors++; $display("FAIL reset_inst0 got %h exp 0", {rdy0, err0, busy0, rd0}); end
    @(negedge CLK); rst2 = 1'b1; rst0 = 1'b1;
  endtask

  task automatic test_write_read;
    int lat; logic e, ra, ba; logic [31:0] rd;
    access(2, 1'b1, 32'h08, 32'hDEADBEEF, lat, e, rd, ra, ba);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", e); end
    checks++; if ({ra, ba} !== 2'b00) begin errors++; $display("FAIL wr_release got %b exp 00", {ra, ba}); end
    access(2, 1'b0, 32'h08, 32'h0, lat, e, rd, ra, ba);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
  endtask

  task automatic test_bad_addr;
    int lat; logic e, ra, ba; logic [31:0] rd;
    access(2, 1'b0, 32'h06, 32'h0, lat, e, rd, ra, ba);
    checks++; if ({e, rd} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL misaligned got err=%b rdata=%h exp err=1 rdata=deadbeef", e, rd); end
    access(2, 1'b0, 32'h100, 32'h0, lat, e, rd, ra, ba);
    checks++; if ({e, rd} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL out_of_range got err=%b rdata=%h exp err=1 rdata=deadbeef", e, rd); end
    access(2, 1'b1, 32'h0A, 32'h11111111, lat, e, rd, ra, ba);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_write_err got %b exp 1", e); end
    access(2, 1'b0, 32'h08, 32'h0, lat, e, rd, ra, ba);
    checks++; if ({e, rd} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL ram_unchanged got err=%b rdata=%h exp err=0 rdata=deadbeef", e, rd); end
  endtask

  task automatic test_hold_req;
    bit seen = 0;
    @(negedge CLK); req2 = 1'b1; rw2 = 1'b0; addr2 = 32'h08;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (rdy2) begin seen = 1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hold_ready_timeout got 0 exp 1"); end
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      checks++; if ({rdy2, busy2, rd2} !== {2'b11, 32'hDEADBEEF}) begin errors++; $display("FAIL hold_cycle%0d got %h exp 3deadbeef", i, {rdy2, busy2, rd2}); end
    end
    @(negedge CLK); req2 = 1'b0;
    @(posedge CLK); #1;
    checks++; if ({rdy2, busy2} !== 2'b00) begin errors++; $display("FAIL hold_release got %b exp 00", {rdy2, busy2}); end
  endtask

  task automatic test_reset_abort;
    int lat; logic e, ra, ba; bit seen = 0; logic [31:0] rd;
    access(2, 1'b1, 32'h10, 32'hA5A5A5A5, lat, e, rd, ra, ba);
    @(negedge CLK); req2 = 1'b1; rw2 = 1'b1; addr2 = 32'h10; wd2 = 32'h12345678;
    @(posedge CLK); #1;
    checks++; if ({busy2, rdy2} !== 2'b10) begin errors++; $display("FAIL abort_accept got %b exp 10", {busy2, rdy2}); end
    @(posedge CLK); #2;
    rst2 = 1'b0; #1;
    checks++; if ({rdy2, err2, busy2, rd2} !== 35'h0) begin errors++; $display("FAIL abort_async got %h exp 0", {rdy2, err2, busy2, rd2}); end
    req2 = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL abort_no_ready got %b exp 0", rdy2); end
    @(negedge CLK); rst2 = 1'b1;
    access(2, 1'b0, 32'h10, 32'h0, lat, e, rd, ra, ba);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL abort_ram got %h exp a5a5a5a5", rd); end
    // Reset while in RESP: the committed write must survive.
    @(negedge CLK); req2 = 1'b1; rw2 = 1'b1; addr2 = 32'h14; wd2 = 32'h0BADF00D;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (rdy2) begin seen = 1; break; end
    end
    #2; rst2 = 1'b0; #1;
    checks++; if ({seen, rdy2, busy2} !== 3'b100) begin errors++; $display("FAIL resp_reset got %b exp 100", {seen, rdy2, busy2}); end
    req2 = 1'b0;
    @(negedge CLK); rst2 = 1'b1;
    access(2, 1'b0, 32'h14, 32'h0, lat, e, rd, ra, ba);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL resp_reset_ram got %h exp 0badf00d", rd); end
  endtask

  task automatic test_back_to_back;
    int lat; logic e, ra, ba; logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      access(0, 1'b1, 32'(i * 4), 32'h10000000 + 32'(i), lat, e, rd, ra, ba);
      checks++; if ({lat, e} !== {32'd1, 1'b0}) begin errors++; $display("FAIL b2b_wr%0d got lat=%0d err=%b exp lat=1 err=0", i, lat, e); end
    end
    @(negedge CLK); req0 = 1'b1; rw0 = 1'b1; addr0 = 32'h0C; wd0 = 32'h10000003;
    @(posedge CLK); #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_wr3_ready got %b exp 1", rdy0); end
    @(negedge CLK); wd0 = 32'hFFFFFFFF;
    @(negedge CLK); req0 = 1'b0;
    @(posedge CLK);
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b0, 32'(i * 4), 32'h0, lat, e, rd, ra, ba);
      checks++; if ({lat, rd} !== {32'd1, 32'h10000000 + 32'(i)}) begin errors++; $display("FAIL b2b_rd%0d got lat=%0d rdata=%h exp lat=1 rdata=%h", i, lat, rd, 32'h10000000 + 32'(i)); end
    end
  endtask

  task automatic test_latched_fields;
    int lat; logic e, ra, ba; bit seen = 0; logic [31:0] rd, prev;
    access(2, 1'b1, 32'h20, 32'hCAFEF00D, lat, e, rd, ra, ba);
    prev = rd2;
    @(negedge CLK); req2 = 1'b1; rw2 = 1'b1; addr2 = 32'h24; wd2 = 32'h55AA55AA;
    @(posedge CLK);
    @(negedge CLK); rw2 = 1'b0; addr2 = 32'h20; wd2 = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (rdy2) begin seen = 1; break; end
    end
    checks++; if ({seen, err2, rd2} !== {2'b10, prev}) begin errors++; $display("FAIL latch_resp got %h exp %h", {seen, err2, rd2}, {2'b10, prev}); end
    @(negedge CLK); req2 = 1'b0;
    @(posedge CLK);
    access(2, 1'b0, 32'h24, 32'h0, lat, e, rd, ra, ba);
    checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL latch_addr got %h exp 55aa55aa", rd); end
    access(2, 1'b0, 32'h20, 32'h0, lat, e, rd, ra, ba);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL latch_other got %h exp cafef00d", rd); end
  endtask

  initial begin
    rst2 = 1'b0; req2 = 1'b0; rw2 = 1'b0; addr2 = '0; wd2 = '0;
    rst0 = 1'b0; req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wd0 = '0;
    test_reset();
    test_write_read();
    test_bad_addr();
    test_hold_req();
    test_reset_abort();
    test_back_to_back();
    test_latched_fields();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
